risc16_mem_arbiter: RTL and testbench
=====================================

# risc16_mem_arbiter

Single-port memory arbiter for the RISC16 core. It shares one synchronous-read, byte-writable SRAM between the core's instruction-fetch port and its data (load/store/byte) port. It issues at most one memory access per cycle and gives the data port priority. An anti-starvation counter guarantees fetch progress. It sits between the core's `iaddr/ioe/idin` and `daddr/doe/dwe0/dwe1/ddin/ddout` ports and the unified memory macro.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive denied fetch cycles after which fetch wins one arbitration. Legal range 1..15.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `i_req`, in, 1: fetch request.
- `i_addr`, in, 16: fetch byte address; bit 0 ignored.
- `i_gnt`, out, 1: fetch accepted this cycle.
- `i_rvalid`, out, 1: fetch data valid.
- `i_rdata`, out, 16: fetch data.
- `d_req`, in, 1: data request.
- `d_addr`, in, 16: data byte address; bit 0 ignored.
- `d_we`, in, 2: byte write enables; [1] selects [15:8], [0] selects [7:0]; 2'b00 means read.
- `d_wdata`, in, 16: write data.
- `d_gnt`, out, 1: data access accepted this cycle.
- `d_rvalid`, out, 1: data read valid.
- `d_rdata`, out, 16: data read value.
- `m_addr`, out, 16: memory address.
- `m_wdata`, out, 16: memory write data.
- `m_oe`, out, 1: memory read enable.
- `m_we`, out, 2: memory byte write enables.
- `m_rdata`, in, 16: memory read data; valid the cycle after `m_oe`.
- `starved`, out, 1: the fetch-priority override is active this cycle.

## Operation
- Requesters hold `req` and the address/data/`we` stable until `gnt`. A request is accepted on the edge at which `gnt` is 1.
- Arbitration is combinational on this cycle's requests. The memory command drives the granted port's fields directly.
- Default priority is data over fetch. When `starve_cnt == STARVE_MAX`, `starved`=1 and fetch wins if `i_req`=1.
- `starve_cnt` (4 bit):
  - increments on each cycle with `i_req`=1 and `i_gnt`=0;
  - clears on `i_gnt`=1 or `i_req`=0;
  - saturates at `STARVE_MAX`.
- Read tag register `rd_owner` has values NONE, I and D. It is loaded each edge with the owner of any read granted that cycle, or NONE.
- Write (`d_we`≠0):
  - `m_we`=`d_we` and `m_wdata`=`d_wdata`, with `m_oe`=0;
  - completes in the grant cycle;
  - produces no `d_rvalid`.
- Read return: in the cycle when `rd_owner`=I (or D), the matching `rvalid`=1 and `rdata`=`m_rdata`.
- Each `rdata` is backed by a hold register captured on its `rvalid` cycle. Outside `rvalid` cycles, `rdata` shows the last returned value.
- Pipelined operation: a new access can be granted in the same cycle that a previous read returns. Back-to-back reads sustain one per cycle.
- No grant while `rst`=0. The memory command is idle when no request is granted: `m_oe`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0.

## Timing
- Values while `rst`=0 and on the first cycle after release:
  - all `gnt`, `rvalid`, `m_oe`, `m_we` and `starved` are 0;
  - `i_rdata` and `d_rdata` are 0x0000;
  - `rd_owner`=NONE and `starve_cnt`=0.
- Grant latency is 0 cycles (combinational on `req`). Read data latency is exactly 1 cycle after the grant.
- Reset asserted while a read is in flight drops it: no `rvalid` after the reset edge, and the hold registers clear.
- Simultaneous `i_req` and `d_req` with `starve_cnt` < `STARVE_MAX`: `d_gnt`=1, `i_gnt`=0.
- With `starve_cnt` == `STARVE_MAX`: `i_gnt`=1, `d_gnt`=0, and the counter clears on that edge.
- `i_gnt` and `d_gnt` are never both 1. `m_oe` and `m_we`≠0 are never both asserted.
- A read-after-write to the same address in consecutive cycles returns the new data. The SRAM is write-first, and writes are never buffered.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `i_req`=`d_req`=1. Required: all grants, `rvalid`, `m_oe` and `m_we` are 0, and `rdata`=0x0000; the first grant appears in the cycle after release.
- Fetch stream: memory[0x0010]=0x1234 and [0x0012]=0x5678; `i_req` for 0x0010 then 0x0012 in consecutive cycles. Required: `i_gnt`=1 in both cycles; `i_rvalid`=1 with 0x1234, then 0x5678; `i_rdata` then holds 0x5678.
- Contention: `i_req`=0x0000 and `d_req` read 0x0100 asserted together. Required: `d_gnt`=1 and `i_gnt`=0 in cycle 0; `i_gnt`=1 in cycle 1; `d_rvalid` in cycle 1; `i_rvalid` in cycle 2.
- Starvation with `STARVE_MAX`=4: `d_req` held continuously with reads and `i_req` held. Required: `i_gnt`=0 for 4 cycles; in cycle 5 `starved`=1, `i_gnt`=1 and `d_gnt`=0; in cycle 6 `d_gnt`=1.
- Byte write: memory[0x0020]=0x1111, then write `d_we`=2'b10 with `d_wdata`=0xAB00, then read 0x0020. Required: `m_we`=2'b10 and no `d_rvalid` for the write; the read returns 0xAB11.
- Reset mid-read: grant a `d` read, then drive `rst`=0 on the next cycle. Required: `d_rvalid` is never 1 and `d_rdata`=0x0000.

Source files
------------

// File: rtl/risc16_mem_arbiter.sv
// Single-port SRAM arbiter for RISC16: the data port normally wins, and fetch wins
// after a bounded run of denied fetch cycles. Read data returns one cycle after the grant.
module risc16_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_oe,
  output logic [1:0]  m_we,
  input  logic [15:0] m_rdata,
  output logic        starved
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // run rises one edge after reset is released, so no grant can occur in the release cycle.
  logic        run;
  owner_t      rd_owner, rd_owner_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [15:0] i_hold, d_hold;
  logic        d_wr;

  always_comb begin
    d_wr         = |d_we;
    starved      = 1'b0;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_oe         = 1'b0;
    m_we         = '0;
    rd_owner_nxt = OWN_NONE;
    starve_nxt   = '0;

    if (rst && run) begin
      starved = (starve_cnt == STARVE_LIM);
      if (starved && i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end

    if (i_gnt) begin
      m_addr       = i_addr;
      m_oe         = 1'b1;
      rd_owner_nxt = OWN_I;
    end else if (d_gnt) begin
      m_addr = d_addr;
      if (d_wr) begin
        m_we    = d_we;
        m_wdata = d_wdata;
      end else begin
        m_oe         = 1'b1;
        rd_owner_nxt = OWN_D;
      end
    end

    // The counter stays clear until grants are enabled, then saturates at the limit.
    if (run && i_req && !i_gnt) begin
      starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run        <= 1'b0;
      rd_owner   <= OWN_NONE;
      starve_cnt <= '0;
      i_hold     <= '0;
      d_hold     <= '0;
    end else begin
      run        <= 1'b1;
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_nxt;
      if (rd_owner == OWN_I) i_hold <= m_rdata;
      if (rd_owner == OWN_D) d_hold <= m_rdata;
    end
  end

  // Returns are gated by rst, so a read in flight when reset is asserted is never reported.
  always_comb begin
    i_rvalid = rst && (rd_owner == OWN_I);
    d_rvalid = rst && (rd_owner == OWN_D);
    i_rdata  = '0;
    d_rdata  = '0;
    if (rst) begin
      i_rdata = i_rvalid ? m_rdata : i_hold;
      d_rdata = d_rvalid ? m_rdata : d_hold;
    end
  end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench for risc16_mem_arbiter with a write-first, synchronous-read SRAM model.
module tb_risc16_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_we;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_oe, starved;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_we;
  logic [15:0] m_rdata;

  logic [15:0] mem [0:32767];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  risc16_mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_oe(m_oe), .m_we(m_we), .m_rdata(m_rdata),
    .starved(starved)
  );

  always @(posedge clk) begin
    if (m_we[1]) mem[m_addr[15:1]][15:8] <= m_wdata[15:8];
    if (m_we[0]) mem[m_addr[15:1]][7:0]  <= m_wdata[7:0];
    if (m_oe)    m_rdata <= mem[m_addr[15:1]];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 2'b00; i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    for (int unsigned k = 0; k < 32768; k++) mem[k] = '0;
    m_rdata = '0;
    mem[16'h0000 >> 1] = 16'hCAFE;
    mem[16'h0010 >> 1] = 16'h1234;
    mem[16'h0012 >> 1] = 16'h5678;
    mem[16'h0020 >> 1] = 16'h1111;
    mem[16'h0100 >> 1] = 16'hBEEF;

    // Reset held with both ports requesting
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_i_gnt", 16'(i_gnt), 16'h0);
      check("rst_d_gnt", 16'(d_gnt), 16'h0);
      check("rst_m_oe", 16'(m_oe), 16'h0);
      check("rst_m_we", 16'(m_we), 16'h0);
      check("rst_rvalid", 16'({i_rvalid, d_rvalid}), 16'h0);
      check("rst_i_rdata", i_rdata, 16'h0000);
      check("rst_d_rdata", d_rdata, 16'h0000);
      cyc();
    end
    rst = 1'b1;
    settle();
    check("rel_gnt", 16'({i_gnt, d_gnt}), 16'h0);
    check("rel_starved", 16'(starved), 16'h0);
    check("rel_rvalid", 16'({i_rvalid, d_rvalid}), 16'h0);
    cyc();
    check("first_d_gnt", 16'(d_gnt), 16'h1);
    check("first_i_gnt", 16'(i_gnt), 16'h0);
    idle();
    cyc();
    check("idle_m_addr", m_addr, 16'h0000);
    check("idle_m_cmd", 16'({m_oe, m_we}), 16'h0);
    cyc();

    // Back-to-back fetches
    i_req = 1'b1; i_addr = 16'h0010;
    settle();
    check("f0_i_gnt", 16'(i_gnt), 16'h1);
    check("f0_m_oe", 16'(m_oe), 16'h1);
    check("f0_m_addr", m_addr, 16'h0010);
    cyc();
    i_addr = 16'h0012;
    settle();
    check("f1_i_gnt", 16'(i_gnt), 16'h1);
    check("f1_i_rvalid", 16'(i_rvalid), 16'h1);
    check("f1_i_rdata", i_rdata, 16'h1234);
    cyc();
    idle();
    settle();
    check("f2_i_rvalid", 16'(i_rvalid), 16'h1);
    check("f2_i_rdata", i_rdata, 16'h5678);
    cyc();
    check("f3_i_rvalid", 16'(i_rvalid), 16'h0);
    check("f3_i_hold", i_rdata, 16'h5678);

    // Contention: data first, fetch next cycle
    i_req = 1'b1; i_addr = 16'h0000; d_req = 1'b1; d_addr = 16'h0100;
    settle();
    check("c0_d_gnt", 16'(d_gnt), 16'h1);
    check("c0_i_gnt", 16'(i_gnt), 16'h0);
    cyc();
    d_req = 1'b0;
    settle();
    check("c1_i_gnt", 16'(i_gnt), 16'h1);
    check("c1_d_rvalid", 16'(d_rvalid), 16'h1);
    check("c1_d_rdata", d_rdata, 16'hBEEF);
    cyc();
    idle();
    settle();
    check("c2_i_rvalid", 16'(i_rvalid), 16'h1);
    check("c2_i_rdata", i_rdata, 16'hCAFE);
    check("c2_d_rvalid", 16'(d_rvalid), 16'h0);
    check("c2_d_hold", d_rdata, 16'hBEEF);
    cyc();

    // Starvation with STARVE_MAX = 4
    i_req = 1'b1; i_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0012;
    for (int k = 1; k <= 4; k++) begin
      settle();
      check("s_i_gnt", 16'(i_gnt), 16'h0);
      check("s_d_gnt", 16'(d_gnt), 16'h1);
      check("s_starved", 16'(starved), 16'h0);
      cyc();
    end
    settle();
    check("s5_starved", 16'(starved), 16'h1);
    check("s5_i_gnt", 16'(i_gnt), 16'h1);
    check("s5_d_gnt", 16'(d_gnt), 16'h0);
    cyc();
    settle();
    check("s6_d_gnt", 16'(d_gnt), 16'h1);
    check("s6_starved", 16'(starved), 16'h0);
    check("s6_i_rdata", i_rdata, 16'h1234);
    cyc();
    idle();
    cyc();

    // Upper-byte write then read back
    d_req = 1'b1; d_addr = 16'h0020; d_we = 2'b10; d_wdata = 16'hAB00;
    settle();
    check("w_d_gnt", 16'(d_gnt), 16'h1);
    check("w_m_we", 16'(m_we), 16'h2);
    check("w_m_oe", 16'(m_oe), 16'h0);
    check("w_m_wdata", m_wdata, 16'hAB00);
    cyc();
    d_we = 2'b00; d_wdata = '0;
    settle();
    check("w_no_rvalid", 16'(d_rvalid), 16'h0);
    check("r_m_wdata", m_wdata, 16'h0000);
    cyc();
    idle();
    settle();
    check("r_d_rvalid", 16'(d_rvalid), 16'h1);
    check("r_d_rdata", d_rdata, 16'hAB11);
    cyc();

    // Reset asserted while a data read is in flight
    d_req = 1'b1; d_addr = 16'h0100;
    settle();
    check("mr_d_gnt", 16'(d_gnt), 16'h1);
    cyc();
    rst = 1'b0; d_req = 1'b0;
    settle();
    check("mr0_d_rvalid", 16'(d_rvalid), 16'h0);
    check("mr0_d_rdata", d_rdata, 16'h0000);
    cyc();
    check("mr1_d_rvalid", 16'(d_rvalid), 16'h0);
    check("mr1_d_rdata", d_rdata, 16'h0000);
    rst = 1'b1;
    cyc();
    cyc();
    check("mr2_d_rvalid", 16'(d_rvalid), 16'h0);
    check("mr2_d_rdata", d_rdata, 16'h0000);
    check("mr2_i_rdata", i_rdata, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
